// File: rtl/axis_hdr_stim_gen_pkg.sv
// Shared types and constants for the AXI-Stream header-insert stimulus generator.
package axis_hdr_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_GAP  = 2'd1,
        ST_SEND = 2'd2,
        ST_DONE = 2'd3
    } hdr_state_e;

    localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
    localparam logic [31:0] CHUNK_K   = 32'h9E37_79B9;

    localparam logic [1:0] MODE_LFSR_RAND  = 2'd0;
    localparam logic [1:0] MODE_LFSR_FIXED = 2'd1;
    localparam logic [1:0] MODE_INCR_FIXED = 2'd2;
    localparam logic [1:0] MODE_LFSR_RAND3 = 2'd3;

    // Right-shift Galois step: feedback taps applied when the bit shifted out is 1.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return (s >> 1) ^ (s[0] ? LFSR_POLY : 32'h0);
    endfunction

endpackage

// File: rtl/axis_hdr_stim_gen_if.sv
// AXI-Stream insert-header channel between the stimulus source and the datapath.
interface axis_hdr_stim_gen_if #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
);
    logic                    ins_valid_m;
    logic [DATA_WD-1:0]      ins_data_m;
    logic [DATA_BYTE_WD-1:0] ins_keep_m;
    logic [BYTE_CNT_WD:0]    ins_byte_insert_cnt;
    logic                    ins_ready_m;

    modport master (
        output ins_valid_m, ins_data_m, ins_keep_m, ins_byte_insert_cnt,
        input  ins_ready_m
    );

    modport slave (
        input  ins_valid_m, ins_data_m, ins_keep_m, ins_byte_insert_cnt,
        output ins_ready_m
    );
endinterface

// File: rtl/axis_hdr_stim_gen_lfsr32.sv
// 32-bit Galois LFSR with seed parameter, advance enable and look-ahead next state.
module lfsr32
    import axis_hdr_pkg::*;
#(
    parameter logic [31:0] SEED = 32'h0000_0001
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        adv,
    output logic [31:0] state,
    output logic [31:0] state_nxt
);
    // An all-zero state would lock the LFSR, so a zero seed is promoted to 1.
    localparam logic [31:0] SEED_NZ = (SEED == 32'h0) ? 32'h1 : SEED;

    assign state_nxt = lfsr_step(state);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= SEED_NZ;
        end else if (adv) begin
            state <= state_nxt;
        end
    end
endmodule

// File: rtl/axis_hdr_stim_gen.sv
// Seeded, throttled AXI-Stream header-insert stimulus source with header-count limit.
//  state | meaning
//  IDLE  | generator off, valid low
//  GAP   | throttle wait before building the next beat
//  SEND  | beat presented, held until handshake
//  DONE  | cfg_num headers accepted, waiting for cfg_en low
module axis_hdr_stim_gen
    import axis_hdr_pkg::*;
#(
    parameter int          DATA_WD      = 32,
    parameter int          DATA_BYTE_WD = DATA_WD / 8,
    parameter int          BYTE_CNT_WD  = $clog2(DATA_BYTE_WD),
    parameter logic [31:0] DATA_SEED    = 32'h0000_0001,
    parameter logic [31:0] THR_SEED     = 32'h1234_5678
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   cfg_en,
    input  logic [1:0]             cfg_mode,
    input  logic [BYTE_CNT_WD:0]   cfg_fixed_cnt,
    input  logic [7:0]             cfg_gap_thresh,
    input  logic [15:0]            cfg_num,
    axis_hdr_stim_gen_if.master    ins,
    output logic [15:0]            hdr_count,
    output logic                   done
);
    localparam int                NCHUNK  = (DATA_WD + 31) / 32;
    localparam int                CNT_WD  = BYTE_CNT_WD + 1;
    localparam logic [CNT_WD-1:0] CNT_ONE = CNT_WD'(1);
    localparam logic [CNT_WD-1:0] CNT_MAX = CNT_WD'(DATA_BYTE_WD);

    hdr_state_e state_q, state_d;

    logic [31:0]             dat_s, dat_s_nxt, thr_s, thr_s_nxt;
    logic                    hs, load, cnt_clr, thr_unused;
    logic [31:0]             src_s;
    logic [7:0]              src_hcnt, incr_base;
    logic [NCHUNK*32-1:0]    raw;
    logic [DATA_WD-1:0]      data_q, beat_data;
    logic [DATA_BYTE_WD-1:0] keep_q, beat_keep;
    logic [CNT_WD-1:0]       cnt_q, beat_cnt;

    assign hs = (state_q == ST_SEND) && ins.ins_ready_m;

    lfsr32 #(.SEED(DATA_SEED)) u_dat_lfsr (
        .clk       (clk),
        .rst_n     (rst_n),
        .adv       (hs),
        .state     (dat_s),
        .state_nxt (dat_s_nxt)
    );

    lfsr32 #(.SEED(THR_SEED)) u_thr_lfsr (
        .clk       (clk),
        .rst_n     (rst_n),
        .adv       (state_q == ST_GAP),
        .state     (thr_s),
        .state_nxt (thr_s_nxt)
    );

    // Only the low byte of the throttle LFSR feeds the gap decision.
    assign thr_unused = ^{thr_s[31:8], thr_s_nxt};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        cnt_clr = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (cfg_en) begin
                    state_d = ST_GAP;
                    cnt_clr = 1'b1;
                end
            end
            ST_GAP: begin
                if (thr_s[7:0] >= cfg_gap_thresh) begin
                    state_d = ST_SEND;
                    load    = 1'b1;
                end else if (!cfg_en) begin
                    state_d = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (hs) begin
                    if ((cfg_num != 16'd0) && (hdr_count + 16'd1 == cfg_num)) begin
                        state_d = ST_DONE;
                    end else if (!cfg_en) begin
                        state_d = ST_IDLE;
                    end else if (cfg_gap_thresh == 8'd0) begin
                        load = 1'b1;
                    end else begin
                        state_d = ST_GAP;
                    end
                end
            end
            ST_DONE: begin
                if (!cfg_en) begin
                    state_d = ST_IDLE;
                end
            end
        endcase
    end

    // A back-to-back reload in SEND must see the LFSR and count as they will be after this handshake.
    assign src_s    = (state_q == ST_SEND) ? dat_s_nxt : dat_s;
    assign src_hcnt = (state_q == ST_SEND) ? 8'(hdr_count) + 8'd1 : 8'(hdr_count);

    always_comb begin
        raw       = '0;
        beat_data = '0;
        beat_keep = '0;
        beat_cnt  = CNT_ONE;
        incr_base = src_hcnt * 8'(DATA_BYTE_WD);
        if ((cfg_mode == MODE_LFSR_FIXED) || (cfg_mode == MODE_INCR_FIXED)) begin
            if (cfg_fixed_cnt == '0) begin
                beat_cnt = CNT_ONE;
            end else if (cfg_fixed_cnt > CNT_MAX) begin
                beat_cnt = CNT_MAX;
            end else begin
                beat_cnt = cfg_fixed_cnt;
            end
        end else begin
            beat_cnt = {1'b0, src_s[BYTE_CNT_WD-1:0]} + CNT_ONE;
        end
        for (int k = 0; k < NCHUNK; k++) begin
            raw[k*32 +: 32] = src_s ^ (32'(k) * CHUNK_K);
        end
        for (int i = 0; i < DATA_BYTE_WD; i++) begin
            beat_keep[i] = (CNT_WD'(i) < beat_cnt);
            if (beat_keep[i]) begin
                beat_data[i*8 +: 8] = (cfg_mode == MODE_INCR_FIXED) ? incr_base + 8'(i)
                                                                     : raw[i*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q <= '0;
            keep_q <= '0;
            cnt_q  <= '0;
        end else if (load) begin
            data_q <= beat_data;
            keep_q <= beat_keep;
            cnt_q  <= beat_cnt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hdr_count <= 16'd0;
        end else if (cnt_clr) begin
            hdr_count <= 16'd0;
        end else if (hs) begin
            hdr_count <= hdr_count + 16'd1;
        end
    end

    assign ins.ins_valid_m         = (state_q == ST_SEND);
    assign ins.ins_data_m          = data_q;
    assign ins.ins_keep_m          = keep_q;
    assign ins.ins_byte_insert_cnt = cnt_q;
    assign done                    = (state_q == ST_DONE);
endmodule

// File: doc/axis_hdr_stim_gen.md
# axis_hdr_stim_gen

Synthesizable, parametrised AXI-Stream header-insert stimulus source driving the insert-header input of the header-insertion datapath. It replaces free-running `$random` stimulus with reproducible seeded LFSRs. It obeys AXI-Stream valid/data stability under backpressure and adds selectable data/byte-count modes, a programmable inter-beat gap and a header-count limit with completion flag.

## Interface
- DATA_WD, 32: data width in bits; power of two, ≥16
- DATA_BYTE_WD, DATA_WD/8: bytes per beat
- BYTE_CNT_WD, $clog2(DATA_BYTE_WD): byte-index width
- DATA_SEED, 32'h0000_0001: data LFSR reset value; 0 is replaced by 1
- THR_SEED, 32'h1234_5678: throttle LFSR reset value; 0 is replaced by 1
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- cfg_en  in  1  generator enable
- cfg_mode  in  2  0: LFSR data, random count; 1: LFSR data, fixed count; 2: incrementing data, fixed count; 3: same as 0
- cfg_fixed_cnt  in  BYTE_CNT_WD+1  byte count for modes 1 and 2
- cfg_gap_thresh  in  8  throttle threshold; 0 means back-to-back beats
- cfg_num  in  16  headers to send; 0 means unlimited
- ins_valid_m  out  1  AXIS valid
- ins_data_m  out  DATA_WD  header data
- ins_keep_m  out  DATA_BYTE_WD  byte enables
- ins_byte_insert_cnt  out  BYTE_CNT_WD+1  valid byte count, 1..DATA_BYTE_WD
- ins_ready_m  in  1  AXIS ready
- hdr_count  out  16  headers accepted since start
- done  out  1  cfg_num headers sent

## Operation
- Both LFSRs are 32-bit right-shift Galois with polynomial 0x80200003.
  - Data LFSR advances only on handshake (valid & ready).
  - Throttle LFSR advances every cycle in GAP.
- Beat build (registered into the outputs on entry to SEND), from data LFSR state S:
  - Byte count, random modes: n = S[BYTE_CNT_WD-1:0] + 1.
  - Byte count, fixed modes: n = cfg_fixed_cnt clamped; 0 becomes 1, values above DATA_BYTE_WD become DATA_BYTE_WD.
  - keep: low n bits set.
  - Data, LFSR modes: chunk k (32 bits) = S ^ (k * 32'h9E37_79B9), truncated.
  - Data, mode 2: byte i = (hdr_count*DATA_BYTE_WD + i)[7:0].
  - Bytes outside keep are forced to 0.
- FSM states: IDLE, GAP, SEND, DONE.
  - IDLE: valid=0. cfg_en=1 → GAP, and hdr_count clears to 0.
  - GAP: valid=0. thr[7:0] ≥ cfg_gap_thresh → SEND (beat loaded). cfg_en=0 → IDLE.
  - SEND: valid=1; all outputs held until handshake. On handshake hdr_count increments, then:
    - cfg_num≠0 and new hdr_count == cfg_num → DONE.
    - else cfg_en=0 → IDLE.
    - else cfg_gap_thresh == 0 → stay in SEND and load the next beat from the advanced LFSR state.
    - else → GAP.
  - DONE: valid=0, done=1. cfg_en=0 → IDLE (done clears).
- cfg_en deassertion never withdraws an asserted valid.
- Config changes affect only subsequently built beats.

## Timing
- Reset values: all outputs 0; state IDLE; LFSRs at their seeds.
- Reset mid-beat: valid drops asynchronously.
- cfg_en rises at edge t → GAP at t+1 → valid high at t+2 at the earliest (thresh 0).
- Back-to-back: with ready tied high, one beat per cycle.
- Gap: each GAP cycle passes with probability (256 - thresh)/256.
- hdr_count and done update on the edge that completes the handshake.
- Fully deterministic: identical seeds and stimulus give bit-identical streams.

## Structure
- Package axis_hdr_pkg holds:
  - FSM state enum
  - LFSR_POLY = 32'h8020_0003
  - chunk constant 32'h9E37_79B9
  - cfg_mode encodings
- Sub-module lfsr32 (seed parameter, advance enable, state out, combinational next-state out) is instantiated twice.

## Test plan
- Basic fixed count: DATA_WD=32, mode 1, fixed_cnt=3, thresh 0, num=4, ready=1 → 4 consecutive beats with keep 4'b0111, cnt 3, data[31:24]=0; done=1 and hdr_count=4 after the 4th edge; then valid=0.
- Backpressure: ready=0 for 10 cycles mid-stream → valid stays 1 and data/keep/cnt stay bit-stable; the beat is accepted on the ready edge.
- Incrementing data: DATA_WD=64, mode 2, fixed_cnt=8 → data 64'h0706050403020100, then 64'h0F0E0D0C0B0A0908; keep 8'hFF.
- Clamp: fixed_cnt=0 → cnt 1, keep 8'h01. fixed_cnt=15 at DATA_WD=64 → cnt 8, keep 8'hFF.
- Random count: mode 0, num=1000 → cnt is always in 1..DATA_BYTE_WD, keep == (1<<cnt)-1, and bytes outside keep are 0. A repeat run with the same seeds matches exactly.
- Disable and reset: cfg_en=0 while valid=1 → valid holds until handshake, then IDLE. rst_n low mid-SEND → valid=0 immediately; after release the first beat equals the post-reset first beat of the reference model.
